// File: rtl/spi_slave_shift_unit.sv
// SPI slave serial engine: synchronises SCLK/SS/MOSI into PCLK, detects mode-dependent
// sample/shift edges, assembles RX words and drives MISO from a single-entry TX buffer.
module spi_slave_shift_unit #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_W-1:0]   ss_sync_q, ss_sync_d;
  logic [SYNC_W-1:0]   mosi_sync_q, mosi_sync_d;
  logic                sclk_dly_q, sclk_dly_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
  logic                tx_ready_q, tx_ready_d;
  logic                load_pending_q, load_pending_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;

  logic                sclk_s, ss_s, mosi_s;
  logic                rise, fall, lead, trail, samp, shft;
  logic                load_now;
  logic [DATA_W-1:0]   rx_word;

  assign sclk_s = sclk_sync_q[SYNC_W-1];
  assign ss_s   = ss_sync_q[SYNC_W-1];
  assign mosi_s = mosi_sync_q[SYNC_W-1];

  assign rise  = sclk_s & ~sclk_dly_q;
  assign fall  = ~sclk_s & sclk_dly_q;
  assign lead  = cpol_i ? fall : rise;
  assign trail = cpol_i ? rise : fall;
  assign samp  = cpha_i ? trail : lead;
  assign shft  = cpha_i ? lead : trail;

  assign rx_word = lsbfe_i ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                           : {rx_shift_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d        = state_q;
    sclk_sync_d    = {sclk_sync_q[SYNC_W-2:0], sclk_i};
    ss_sync_d      = {ss_sync_q[SYNC_W-2:0], ss_i};
    mosi_sync_d    = {mosi_sync_q[SYNC_W-2:0], mosi_i};
    sclk_dly_d     = sclk_s;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    tx_shift_d     = tx_shift_q;
    tx_buf_d       = tx_buf_q;
    tx_ready_d     = tx_ready_q;
    load_pending_d = load_pending_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    load_now       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ss_s && spe_i) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          if (cpha_i) load_pending_d = 1'b1;
          else        load_now       = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect aborts immediately; any partial word is simply dropped.
        if (ss_s || !spe_i) begin
          state_d        = IDLE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
          tx_shift_d     = '0;
        end else if (samp) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
            rx_data_d      = rx_word;
            rx_valid_d     = 1'b1;
            bit_cnt_d      = '0;
            load_pending_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shft) begin
          if (load_pending_q) begin
            load_now       = 1'b1;
            load_pending_d = 1'b0;
          end else if (lsbfe_i) begin
            tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_now) begin
      if (!tx_ready_q) begin
        tx_shift_d = tx_buf_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = '1;
        underrun_d = 1'b1;
      end
    end

    // A write is judged against the pre-load buffer state, so it can land
    // in the same cycle an empty buffer underruns.
    if (tx_load_i && tx_ready_q) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q        <= IDLE;
      sclk_sync_q    <= '0;
      ss_sync_q      <= '1;
      mosi_sync_q    <= '0;
      sclk_dly_q     <= 1'b0;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      tx_buf_q       <= '0;
      tx_ready_q     <= 1'b1;
      load_pending_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sclk_sync_q    <= sclk_sync_d;
      ss_sync_q      <= ss_sync_d;
      mosi_sync_q    <= mosi_sync_d;
      sclk_dly_q     <= sclk_dly_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      tx_buf_q       <= tx_buf_d;
      tx_ready_q     <= tx_ready_d;
      load_pending_q <= load_pending_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
    end
  end

  assign busy_o        = (state_q == ACTIVE);
  assign miso_oe_o     = (state_q == ACTIVE);
  assign miso_o        = (state_q == ACTIVE) &
                         (lsbfe_i ? tx_shift_q[0] : tx_shift_q[DATA_W-1]);
  assign tx_ready_o    = tx_ready_q;
  assign tx_underrun_o = underrun_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_shift_unit.sv
// Bench for spi_slave_shift_unit: a behavioural SPI master drives frames in every mode,
// a forked monitor scores each rx_valid_o pulse against a queue of expected words.
module tb_spi_slave_shift_unit;

  localparam int H = 8;

  logic       PCLK;
  logic       PRESET;
  logic       spe, cpol, cpha, lsbfe;
  logic       sclk, ss, mosi;
  logic       miso, misoOe;
  logic [7:0] txData;
  logic       txLoad;
  logic       txReady, txUnderrun;
  logic [7:0] rxData;
  logic       rxValid, busy;

  int         checks;
  int         errors;
  int         underrunCount;
  int         validCount;
  logic [7:0] rxExp[$];

  spi_slave_shift_unit #(.DATA_W(8), .SYNC_W(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .spe_i(spe), .cpol_i(cpol), .cpha_i(cpha),
    .lsbfe_i(lsbfe), .sclk_i(sclk), .ss_i(ss), .mosi_i(mosi), .miso_o(miso),
    .miso_oe_o(misoOe), .tx_data_i(txData), .tx_load_i(txLoad),
    .tx_ready_o(txReady), .tx_underrun_o(txUnderrun), .rx_data_o(rxData),
    .rx_valid_o(rxValid), .busy_o(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // Scoreboard monitor: every rx_valid_o pulse must match the oldest queued word.
  task automatic monitorRx();
    logic [7:0] exp;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        if (txUnderrun) underrunCount++;
        if (rxValid) begin
          validCount++;
          if (rxExp.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no rx_valid", rxData);
          end else begin
            exp = rxExp.pop_front();
            checkOutput("rx_word", 32'(rxData), 32'(exp));
          end
        end
      end
    end
  endtask

  // Write one word into the TX buffer with a single-cycle strobe.
  task automatic applyStimulus(input logic [7:0] d);
    txData = d;
    txLoad = 1'b1;
    waitCycles(1);
    txLoad = 1'b0;
    waitCycles(1);
  endtask

  task automatic setMode(input logic cp, input logic ch, input logic lf);
    cpol  = cp;
    cpha  = ch;
    lsbfe = lf;
    sclk  = cp;
    waitCycles(6);
  endtask

  task automatic selectSlave();
    ss = 1'b0;
    waitCycles(6);
  endtask

  task automatic deselectSlave();
    ss = 1'b1;
    waitCycles(6);
  endtask

  // Master side of one frame: drives MOSI, captures MISO at each sample edge and
  // confirms MISO has not moved a few cycles after that edge.
  task automatic sendFrame(input logic [7:0] word, input int nbits,
                           output logic [7:0] cap, output logic stable);
    cap    = 8'h00;
    stable = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      int   pos;
      logic seen;
      pos = lsbfe ? i : 7 - i;
      if (!cpha) begin
        mosi = word[pos];
        waitCycles(H);
        seen     = miso;
        cap[pos] = seen;
        sclk     = ~cpol;
        waitCycles(4);
        if (miso !== seen) stable = 1'b0;
        waitCycles(H - 4);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = word[pos];
        waitCycles(H);
        seen     = miso;
        cap[pos] = seen;
        sclk     = cpol;
        waitCycles(4);
        if (miso !== seen) stable = 1'b0;
        waitCycles(H - 4);
      end
    end
    waitCycles(H);
  endtask

  initial begin
    logic [7:0] cap;
    logic       stable;
    int         base;

    checks        = 0;
    errors        = 0;
    underrunCount = 0;
    validCount    = 0;
    PRESET = 1'b1;
    spe    = 1'b1;
    cpol   = 1'b0;
    cpha   = 1'b0;
    lsbfe  = 1'b0;
    sclk   = 1'b0;
    ss     = 1'b1;
    mosi   = 1'b0;
    txData = 8'h00;
    txLoad = 1'b0;
    fork
      monitorRx();
    join_none

    waitCycles(3);
    checkOutput("reset_outputs",
                32'({miso, misoOe, txReady, txUnderrun, rxValid, busy, rxData}),
                32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    PRESET = 1'b0;
    waitCycles(3);

    // Mode 0, MSB first, basic exchange.
    setMode(1'b0, 1'b0, 1'b0);
    applyStimulus(8'hA5);
    checkOutput("t1_ready_after_load", 32'(txReady), 32'(0));
    base = underrunCount;
    selectSlave();
    checkOutput("t1_busy_oe_ready", 32'({busy, misoOe, txReady}), 32'(3'b111));
    rxExp.push_back(8'h3C);
    sendFrame(8'h3C, 8, cap, stable);
    checkOutput("t1_master_rx", 32'(cap), 32'(8'hA5));
    checkOutput("t1_miso_stable", 32'(stable), 32'(1));
    deselectSlave();
    checkOutput("t1_rx_held", 32'(rxData), 32'(8'h3C));
    checkOutput("t1_underrun_end", 32'(underrunCount - base), 32'(1));
    checkOutput("t1_rx_pending", 32'(rxExp.size()), 32'(0));

    // All CPOL/CPHA modes with both bit orders.
    for (int m = 0; m < 8; m++) begin
      setMode(m[2], m[1], m[0]);
      applyStimulus(8'h81);
      selectSlave();
      rxExp.push_back(8'h7E);
      sendFrame(8'h7E, 8, cap, stable);
      checkOutput($sformatf("t2_mode%0d%0d_lsb%0d_rx", m[2], m[1], m[0]), 32'(cap), 32'(8'h81));
      checkOutput($sformatf("t2_mode%0d%0d_lsb%0d_stable", m[2], m[1], m[0]), 32'(stable), 32'(1));
      deselectSlave();
    end

    // Asymmetric words so a bit-order slip shows up.
    setMode(1'b1, 1'b1, 1'b1);
    applyStimulus(8'h35);
    selectSlave();
    rxExp.push_back(8'hC2);
    sendFrame(8'hC2, 8, cap, stable);
    checkOutput("t2b_mode3_lsb_rx", 32'(cap), 32'(8'h35));
    deselectSlave();
    setMode(1'b1, 1'b0, 1'b1);
    applyStimulus(8'h0B);
    selectSlave();
    rxExp.push_back(8'hD4);
    sendFrame(8'hD4, 8, cap, stable);
    checkOutput("t2b_mode2_lsb_rx", 32'(cap), 32'(8'h0B));
    deselectSlave();
    checkOutput("t2_rx_pending", 32'(rxExp.size()), 32'(0));

    // Back-to-back frames, buffer not refilled before the second.
    setMode(1'b0, 1'b1, 1'b0);
    applyStimulus(8'h5A);
    base = underrunCount;
    selectSlave();
    rxExp.push_back(8'h12);
    sendFrame(8'h12, 8, cap, stable);
    checkOutput("t3_first_rx", 32'(cap), 32'(8'h5A));
    rxExp.push_back(8'h34);
    sendFrame(8'h34, 8, cap, stable);
    checkOutput("t3_second_rx", 32'(cap), 32'(8'hFF));
    checkOutput("t3_underrun_once", 32'(underrunCount - base), 32'(1));
    deselectSlave();
    checkOutput("t3_rx_held", 32'(rxData), 32'(8'h34));
    checkOutput("t3_rx_pending", 32'(rxExp.size()), 32'(0));

    // Abort after five bits, then a clean frame.
    setMode(1'b0, 1'b0, 1'b0);
    applyStimulus(8'h66);
    base = validCount;
    selectSlave();
    sendFrame(8'h2D, 5, cap, stable);
    ss = 1'b1;
    waitCycles(4);
    checkOutput("t4_abort_idle", 32'({busy, misoOe, miso}), 32'(0));
    waitCycles(4);
    checkOutput("t4_no_rx_valid", 32'(validCount - base), 32'(0));
    applyStimulus(8'h99);
    selectSlave();
    rxExp.push_back(8'hC3);
    sendFrame(8'hC3, 8, cap, stable);
    checkOutput("t4_next_frame_rx", 32'(cap), 32'(8'h99));
    deselectSlave();
    checkOutput("t4_rx_pending", 32'(rxExp.size()), 32'(0));

    // Second write while full must be dropped.
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("t5_ready_still_full", 32'(txReady), 32'(0));
    selectSlave();
    rxExp.push_back(8'h0F);
    sendFrame(8'h0F, 8, cap, stable);
    checkOutput("t5_first_kept", 32'(cap), 32'(8'h11));
    deselectSlave();

    // Asynchronous reset mid-frame, then recovery.
    applyStimulus(8'hF0);
    selectSlave();
    sendFrame(8'hAA, 3, cap, stable);
    PRESET = 1'b1;
    #1;
    checkOutput("t6_reset_outputs",
                32'({miso, misoOe, txReady, txUnderrun, rxValid, busy, rxData}),
                32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
    ss = 1'b1;
    waitCycles(3);
    PRESET = 1'b0;
    waitCycles(3);
    applyStimulus(8'hE7);
    selectSlave();
    rxExp.push_back(8'h5A);
    sendFrame(8'h5A, 8, cap, stable);
    checkOutput("t6_after_reset_rx", 32'(cap), 32'(8'hE7));
    deselectSlave();
    checkOutput("t6_rx_pending", 32'(rxExp.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
